seq_multiplier: RTL

//   Unsigned sequential shift-and-add multiplier, one partial product per clock.

---
 rtl/seq_multiplier_if.sv | 28 ++
 rtl/seq_multiplier.sv | 118 +++++++++++
 2 files changed

// File: rtl/seq_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module  : seq_multiplier_if
// Purpose : Operand-in / product-out valid-ready bundle for seq_multiplier.
// Rev     : 1.0  initial release
// ============================================================================
interface seq_multiplier_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );
endinterface
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module  : seq_multiplier
// Purpose : Unsigned shift-and-add multiplier, one partial product per clock.
// Rev     : 1.0  initial release
// ============================================================================
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  seq_multiplier_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic [WIDTH:0]       carry;

  assign addend   = acc_lo_q[0] ? mcand_q : '0;
  assign carry[0] = 1'b0;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
      full_adder u_fa (
        .a_i (acc_hi_q[i]),
        .b_i (addend[i]),
        .c_i (carry[i]),
        .s_o (sum[i]),
        .c_o (carry[i+1])
      );
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          mcand_d  = bus.a;
          acc_lo_d = bus.b;
          acc_hi_d = '0;
          cnt_d    = '0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        // Shift {carry, sum, acc_lo} right by one; carry-out lands in the MSB.
        acc_hi_d = {carry[WIDTH], sum[WIDTH-1:1]};
        acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST) begin
          product_d = {carry[WIDTH], sum, acc_lo_q[WIDTH-1:1]};
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.product   = product_q;
endmodule
`default_nettype wire
